// File: rtl/axi4_wr_burst_master_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst master and a memory-mapped slave.
interface axi4_wr_burst_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID,
    output BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID,
    input  BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/axi4_wr_burst_master.sv
// Turns one command (addr, len, seed) into a single AXI4 INCR write burst and reports BRESP.
// Optional AXI_WR_4K_CHECK_EN: bursts crossing a 4KB boundary are refused with SLVERR, no bus activity.
//
// state | meaning
// IDLE  | ready for a command
// ADDR  | AW channel valid, waiting for AWREADY
// DATA  | W beats in progress, beat counter tracks position
// RESP  | waiting for the B response
module axi4_wr_burst_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_seed,
  output logic                  done_valid,
  output logic [1:0]            done_resp,
  axi4_wr_burst_master_if.master bus
);

  localparam int SIZE = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state_q, state_d;
  logic                  out_of_rst_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [7:0]            beat_q;

  logic cmd_fire, aw_fire, w_fire, b_fire, last_beat, cross_4k;

  // cmd_ready stays low through reset and rises only after the first clean edge
  assign cmd_ready = (state_q == IDLE) && out_of_rst_q;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign aw_fire   = (state_q == ADDR) && bus.AWREADY;
  assign w_fire    = (state_q == DATA) && bus.WREADY;
  assign b_fire    = (state_q == RESP) && bus.BVALID;
  assign last_beat = (beat_q == len_q);

`ifdef AXI_WR_4K_CHECK_EN
  logic [13:0] end_off;
  assign end_off  = 14'(cmd_addr[11:0] & 12'(ADDR_MASK)) + (14'({1'b0, cmd_len} + 9'd1) << SIZE);
  assign cross_4k = end_off > 14'd4096;
`else
  assign cross_4k = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_fire && !cross_4k) state_d = ADDR;
      ADDR: if (aw_fire) state_d = DATA;
      DATA: if (w_fire && last_beat) state_d = RESP;
      RESP: if (b_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      out_of_rst_q <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      seed_q       <= '0;
      beat_q       <= '0;
      done_valid   <= 1'b0;
      done_resp    <= 2'b00;
    end else begin
      state_q      <= state_d;
      out_of_rst_q <= 1'b1;
      done_valid   <= 1'b0;
      if (cmd_fire) begin
        if (cross_4k) begin
          done_valid <= 1'b1;
          done_resp  <= 2'b10;
        end else begin
          addr_q <= cmd_addr;
          len_q  <= cmd_len;
          seed_q <= cmd_seed;
          beat_q <= '0;
        end
      end
      // counter parks on the last beat so a 256-beat burst never wraps
      if (w_fire && !last_beat) beat_q <= beat_q + 8'd1;
      if (b_fire) begin
        done_valid <= 1'b1;
        done_resp  <= bus.BRESP;
      end
    end
  end

  assign bus.AWADDR  = addr_q & ADDR_MASK;
  assign bus.AWLEN   = len_q;
  assign bus.AWSIZE  = 3'(SIZE);
  assign bus.AWBURST = 2'b01;
  assign bus.AWVALID = (state_q == ADDR);
  assign bus.WDATA   = seed_q + DATA_WIDTH'(beat_q);
  assign bus.WSTRB   = (state_q == DATA) ? '1 : '0;
  assign bus.WLAST   = (state_q == DATA) && last_beat;
  assign bus.WVALID  = (state_q == DATA);
  assign bus.BREADY  = (state_q == RESP);

endmodule

// File: tb/tb_axi4_wr_burst_master.sv
// Directed bench for axi4_wr_burst_master: expected W beats and responses queued at command time.
module tb_axi4_wr_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] cmd_seed;
  logic        done_valid;
  logic [1:0]  done_resp;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t      w_q[$];
  logic [1:0] r_q[$];

  axi4_wr_burst_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  axi4_wr_burst_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_seed   (cmd_seed),
    .done_valid (done_valid),
    .done_resp  (done_resp),
    .bus        (bus.master)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_awvalid"}, bus.AWVALID, 0);
    check({tag, "_wvalid"},  bus.WVALID, 0);
    check({tag, "_wlast"},   bus.WLAST, 0);
    check({tag, "_bready"},  bus.BREADY, 0);
    check({tag, "_done"},    done_valid, 0);
    check({tag, "_awaddr"},  bus.AWADDR, 0);
    check({tag, "_awlen"},   bus.AWLEN, 0);
    check({tag, "_wdata"},   bus.WDATA, 0);
    check({tag, "_wstrb"},   bus.WSTRB, 0);
  endtask

  task automatic run_cmd(input logic [15:0] addr, input logic [7:0] len, input logic [31:0] seed,
                         input logic [1:0] resp, input int aw_stall, input int stall_beat,
                         input int stall_cycles, input int abort_beat);
    beat_t b;
    beat_t e;
    int    beats   = 0;
    int    stalled = 0;
    bit    got_last = 0;
    for (int i = 0; i <= int'(len); i++) begin
      b.data = seed + 32'(i);
      b.last = (i == int'(len));
      w_q.push_back(b);
    end
    r_q.push_back(resp);

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_addr    = addr;
    cmd_len     = len;
    cmd_seed    = seed;
    bus.BRESP   = resp;
    bus.AWREADY = (aw_stall == 0);
    @(negedge ACLK);
    // hold a bogus command while busy; it must not be latched
    cmd_addr = 16'hBEEC;
    cmd_len  = 8'h11;
    cmd_seed = 32'hDEAD_0000;
    check("cmd_ready_busy", cmd_ready, 0);

    for (int i = 0; i <= aw_stall; i++) begin
      check("awvalid", bus.AWVALID, 1);
      check("awaddr", bus.AWADDR, addr & 16'hFFFC);
      check("awlen", bus.AWLEN, len);
      check("awsize", bus.AWSIZE, 3'd2);
      check("awburst", bus.AWBURST, 2'b01);
      check("wvalid_before_aw", bus.WVALID, 0);
      bus.AWREADY = (i == aw_stall);
      @(negedge ACLK);
    end
    cmd_valid = 1'b0;
    check("awvalid_after_hs", bus.AWVALID, 0);

    for (int cyc = 0; cyc < 600 && !got_last; cyc++) begin
      check("done_quiet", done_valid, 0);
      check("bready_quiet", bus.BREADY, 0);
      check("wvalid", bus.WVALID, 1);
      if (beats == abort_beat) begin
        ARESETn     = 1'b0;
        bus.WREADY  = 1'b0;
        @(negedge ACLK);
        check_all_idle("abort");
        check("abort_cmd_ready", cmd_ready, 0);
        w_q.delete();
        r_q.delete();
        ARESETn = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge ACLK);
          check("abort_no_done", done_valid, 0);
          check("abort_awvalid", bus.AWVALID, 0);
        end
        return;
      end
      if (beats == stall_beat && stalled < stall_cycles) begin
        bus.WREADY = 1'b0;
        stalled++;
      end else begin
        bus.WREADY = 1'b1;
      end
      e = w_q[0];
      check("wdata", bus.WDATA, e.data);
      check("wlast", bus.WLAST, e.last);
      check("wstrb", bus.WSTRB, 4'hF);
      if (bus.WREADY) begin
        void'(w_q.pop_front());
        beats++;
        got_last = e.last;
      end
      @(negedge ACLK);
    end
    check("w_complete", got_last, 1);
    check("w_beats", beats, int'(len) + 1);
    bus.WREADY = 1'b0;
    w_q.delete();

    check("wvalid_after_last", bus.WVALID, 0);
    check("bready", bus.BREADY, 1);
    check("done_early", done_valid, 0);
    @(negedge ACLK);
    check("done_pulse", done_valid, 1);
    check("done_resp", done_resp, r_q.pop_front());
    check("cmd_ready_after_b", cmd_ready, 1);
    check("bready_after_b", bus.BREADY, 0);
    @(negedge ACLK);
    check("done_one_cycle", done_valid, 0);
  endtask

  initial begin
    ARESETn     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    cmd_seed    = '0;
    bus.AWREADY = 1'b1;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b1;
    bus.BRESP   = 2'b00;

    repeat (3) begin
      @(negedge ACLK);
      check("rst_cmd_ready", cmd_ready, 0);
    end
    check_all_idle("rst");
    check("rst_done_resp", done_resp, 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("cmd_ready_after_rst", cmd_ready, 1);

    run_cmd(16'h0100, 8'd3, 32'h0000_00A0, 2'b00, 0, -1, 0, -1);
    run_cmd(16'h0100, 8'd3, 32'h0000_00A0, 2'b00, 0, 1, 2, -1);
    run_cmd(16'h0003, 8'd0, 32'hFFFF_FFFF, 2'b10, 1, -1, 0, -1);
    run_cmd(16'h0200, 8'd7, 32'h0000_1000, 2'b00, 0, -1, 0, 2);
    run_cmd(16'h0204, 8'd7, 32'h0000_0055, 2'b01, 0, 3, 1, -1);
    run_cmd(16'h0400, 8'd255, 32'hFFFF_FFF0, 2'b11, 0, 200, 1, -1);

`ifdef AXI_WR_4K_CHECK_EN
    check("4k_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = 16'h0FF0;
    cmd_len   = 8'd7;
    cmd_seed  = 32'h0000_0077;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    check("4k_awvalid", bus.AWVALID, 0);
    check("4k_wvalid", bus.WVALID, 0);
    check("4k_done", done_valid, 1);
    check("4k_resp", done_resp, 2'b10);
    check("4k_cmd_ready_back", cmd_ready, 1);
    @(negedge ACLK);
    check("4k_done_one_cycle", done_valid, 0);
    check("4k_no_aw", bus.AWVALID, 0);
`else
    run_cmd(16'h0FF0, 8'd7, 32'h0000_0077, 2'b00, 0, -1, 0, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_wr_burst_master.md
Name: axi4_wr_burst_master

Overview:
- Upstream AXI4 write-channel driver feeding the AXI4 memory-mapped slave on the shared bus interface.
- Converts a simple command (address, burst length, data seed) into one complete AXI4 INCR write burst: AW, then W beats, then B.
- Reports the write response back to the command side.
- Used as a synthesizable traffic source in the slave's verification top.

Parameters:
- ADDR_WIDTH, 16, width of command and AWADDR address
- DATA_WIDTH, 32, width of WDATA; legal values 8/16/32/64
- STRB_WIDTH, DATA_WIDTH/8, width of WSTRB

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_addr  in  ADDR_WIDTH  burst start byte address
- cmd_len  in  8  AWLEN value; beats = cmd_len+1
- cmd_seed  in  DATA_WIDTH  data value of beat 0
- done_valid  out  1  one-cycle pulse: burst finished
- done_resp  out  2  response captured for finished burst
- AWADDR  out  ADDR_WIDTH  write address
- AWLEN  out  8  burst length
- AWSIZE  out  3  log2(STRB_WIDTH), constant
- AWBURST  out  2  constant 2'b01 (INCR)
- AWVALID  out  1  address valid
- AWREADY  in  1  address ready
- WDATA  out  DATA_WIDTH  write data
- WSTRB  out  STRB_WIDTH  all ones during beats
- WLAST  out  1  final beat marker
- WVALID  out  1  data valid
- WREADY  in  1  data ready
- BRESP  in  2  write response
- BVALID  in  1  response valid
- BREADY  out  1  response ready

Behaviour:
- One clock (ACLK); reset synchronous, active-low (ARESETn).
- Reset values:
  - cmd_ready=0 during reset, 1 on the first cycle after release.
  - done_valid=0, done_resp=0, AWVALID=0, WVALID=0, WLAST=0, BREADY=0.
  - AWADDR=0, AWLEN=0, WDATA=0, WSTRB=0.
  - State=IDLE, beat counter=0.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch addr/len/seed and go to ADDR.
  - ADDR: AWVALID=1. AWADDR=latched addr with low log2(STRB_WIDTH) bits forced to 0. AWLEN=latched len. On AWVALID&&AWREADY, go to DATA.
  - DATA: WVALID=1, WSTRB=all ones. WDATA=seed+beat (modulo 2^DATA_WIDTH). WLAST=(beat==len). Each WVALID&&WREADY increments beat. The handshake with WLAST=1 goes to RESP.
  - RESP: BREADY=1. On BVALID&&BREADY, capture BRESP into done_resp, pulse done_valid for exactly one cycle, and return to IDLE.
- Latency:
  - Command accepted at edge N: AWVALID high from cycle N+1.
  - AW handshake at edge M: WVALID high from M+1.
  - B handshake at edge K: done_valid high in cycle K+1, together with cmd_ready=1.
- Handshake rules:
  - Once asserted, a VALID and its payload stay stable until the matching READY is sampled high.
  - W beats are never issued before the AW handshake completes.
  - Only one burst is outstanding at a time.
- cmd_ready is low outside IDLE; cmd_valid in those states is ignored with no latch.
- AWREADY/WREADY may be high before VALID; a handshake happens only when both are high on the same edge.
- BVALID outside RESP is ignored; BREADY stays low.
- cmd_len=0: single beat, WLAST=1 on beat 0.
- cmd_len=255: 256 beats. Beat counter is 8 bits and does not wrap before WLAST.
- ARESETn low mid-burst: all outputs return to reset values at that edge. The in-flight burst is abandoned and done_valid is not generated.

Optional Feature:
- Macro: AXI_WR_4K_CHECK_EN
- Defined:
  - On accept, compute aligned cmd_addr[11:0] + (cmd_len+1)*STRB_WIDTH.
  - If the result exceeds 4096, no AW/W/B activity occurs.
  - FSM goes to RESP-bypass; done_valid pulses at N+1 with done_resp=2'b10 (SLVERR); cmd_ready returns to 1 in that same cycle.
- Not defined: every command is issued unchanged, including 4KB-crossing bursts.

Test Plan:
- Reset with ARESETn=0 for 3 cycles, then release -> all outputs 0 in reset; cmd_ready=1 on the first cycle after release.
- cmd addr=0x0100, len=3, seed=0xA0, AWREADY/WREADY/BVALID always high, BRESP=0 -> AWADDR=0x0100, AWLEN=3, AWSIZE=2, AWBURST=1; WDATA A0,A1,A2,A3; WLAST only on A3; done_valid one cycle with done_resp=0.
- Same command with WREADY low for 2 cycles at beat 1 -> WDATA stays 0xA1 and WVALID stays high until accepted; 4 total handshakes.
- len=0, addr=0x0003, seed=0xFFFFFFFF, BRESP=2'b10 -> AWADDR=0x0000; single beat with WLAST=1; done_resp=2'b10.
- ARESETn low during beat 2 of a len=7 burst -> all VALIDs 0 next edge; no done_valid; next command runs normally.
- With AXI_WR_4K_CHECK_EN: addr=0x0FF0, len=7, STRB_WIDTH=4 -> no AWVALID; done_valid with done_resp=2'b10. Without the macro: burst issued normally.
